// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipe_stage_skid : parametrised pipeline stage register with 2-entry skid
// buffer, operand forwarding at capture and on held entries, and perf counters.
// Revision: 1.0
// ---------------------------------------------------------------------------
module pipe_stage_skid #(
  parameter int DATA_W         = 32,
  parameter int NUM_OPS        = 2,
  parameter int PAYLOAD_W      = 64,
  parameter bit CLEAR_ON_FLUSH = 1'b1,
  parameter int CNT_W          = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_W-1:0]           in_pc,
  input  logic [PAYLOAD_W-1:0]        in_payload,
  input  logic [NUM_OPS*DATA_W-1:0]   in_ops,
  input  logic [NUM_OPS-1:0]          cap_fwd_en,
  input  logic [NUM_OPS*DATA_W-1:0]   cap_fwd_data,
  input  logic [NUM_OPS-1:0]          hold_fwd_en,
  input  logic [NUM_OPS*DATA_W-1:0]   hold_fwd_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_pc,
  output logic [PAYLOAD_W-1:0]        out_payload,
  output logic [NUM_OPS*DATA_W-1:0]   out_ops,
  output logic [CNT_W-1:0]            stall_cnt,
  output logic [CNT_W-1:0]            flush_cnt
);

  logic                      main_valid_q, main_valid_d;
  logic [DATA_W-1:0]         main_pc_q, main_pc_d;
  logic [PAYLOAD_W-1:0]      main_payload_q, main_payload_d;
  logic [NUM_OPS*DATA_W-1:0] main_ops_q, main_ops_d;
  logic                      skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0]         skid_pc_q, skid_pc_d;
  logic [PAYLOAD_W-1:0]      skid_payload_q, skid_payload_d;
  logic [NUM_OPS*DATA_W-1:0] skid_ops_q, skid_ops_d;
  logic [CNT_W-1:0]          stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]          flush_cnt_q, flush_cnt_d;

  logic                      in_fire;
  logic                      main_free;
  logic [NUM_OPS*DATA_W-1:0] cap_ops;
  logic [NUM_OPS*DATA_W-1:0] main_ref_ops;
  logic [NUM_OPS*DATA_W-1:0] skid_ref_ops;

  assign in_ready  = !skid_valid_q;
  assign in_fire   = in_valid && !skid_valid_q;
  // Main can take a new entry when it is empty or being consumed this edge.
  assign main_free = !main_valid_q || out_ready;

  for (genvar i = 0; i < NUM_OPS; i++) begin : g_ops
    assign cap_ops[i*DATA_W +: DATA_W]      = cap_fwd_en[i]  ? cap_fwd_data[i*DATA_W +: DATA_W]
                                                             : in_ops[i*DATA_W +: DATA_W];
    assign main_ref_ops[i*DATA_W +: DATA_W] = hold_fwd_en[i] ? hold_fwd_data[i*DATA_W +: DATA_W]
                                                             : main_ops_q[i*DATA_W +: DATA_W];
    assign skid_ref_ops[i*DATA_W +: DATA_W] = hold_fwd_en[i] ? hold_fwd_data[i*DATA_W +: DATA_W]
                                                             : skid_ops_q[i*DATA_W +: DATA_W];
  end

  always_comb begin
    main_valid_d   = main_valid_q;
    main_pc_d      = main_pc_q;
    main_payload_d = main_payload_q;
    main_ops_d     = main_ops_q;
    skid_valid_d   = skid_valid_q;
    skid_pc_d      = skid_pc_q;
    skid_payload_d = skid_payload_q;
    skid_ops_d     = skid_ops_q;

    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
      if (CLEAR_ON_FLUSH) begin
        main_pc_d      = '0;
        main_payload_d = '0;
        main_ops_d     = '0;
        skid_pc_d      = '0;
        skid_payload_d = '0;
        skid_ops_d     = '0;
      end
    end else if (main_free) begin
      if (skid_valid_q) begin
        // Skid drains into main carrying this cycle's refreshed operands.
        main_valid_d   = 1'b1;
        main_pc_d      = skid_pc_q;
        main_payload_d = skid_payload_q;
        main_ops_d     = skid_ref_ops;
        skid_valid_d   = 1'b0;
      end else if (in_fire) begin
        main_valid_d   = 1'b1;
        main_pc_d      = in_pc;
        main_payload_d = in_payload;
        main_ops_d     = cap_ops;
      end else begin
        main_valid_d   = 1'b0;
      end
    end else begin
      main_ops_d = main_ref_ops;
      if (skid_valid_q) begin
        skid_ops_d = skid_ref_ops;
      end else if (in_fire) begin
        skid_valid_d   = 1'b1;
        skid_pc_d      = in_pc;
        skid_payload_d = in_payload;
        skid_ops_d     = cap_ops;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (main_valid_q && !out_ready && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + 1'b1;
    if (flush && (main_valid_q || skid_valid_q) && (flush_cnt_q != {CNT_W{1'b1}}))
      flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_q   <= 1'b0;
      main_pc_q      <= '0;
      main_payload_q <= '0;
      main_ops_q     <= '0;
      skid_valid_q   <= 1'b0;
      skid_pc_q      <= '0;
      skid_payload_q <= '0;
      skid_ops_q     <= '0;
      stall_cnt_q    <= '0;
      flush_cnt_q    <= '0;
    end else begin
      main_valid_q   <= main_valid_d;
      main_pc_q      <= main_pc_d;
      main_payload_q <= main_payload_d;
      main_ops_q     <= main_ops_d;
      skid_valid_q   <= skid_valid_d;
      skid_pc_q      <= skid_pc_d;
      skid_payload_q <= skid_payload_d;
      skid_ops_q     <= skid_ops_d;
      stall_cnt_q    <= stall_cnt_d;
      flush_cnt_q    <= flush_cnt_d;
    end
  end

  assign out_valid   = main_valid_q;
  assign out_pc      = main_pc_q;
  assign out_payload = main_payload_q;
  assign out_ops     = main_ops_q;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pipe_stage_skid : directed-vector bench for pipe_stage_skid.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_pipe_stage_skid;

  localparam int DATA_W    = 32;
  localparam int NUM_OPS   = 2;
  localparam int PAYLOAD_W = 64;
  localparam int CNT_W     = 4;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      flush;
  logic                      in_valid;
  logic [DATA_W-1:0]         in_pc;
  logic [PAYLOAD_W-1:0]      in_payload;
  logic [NUM_OPS*DATA_W-1:0] in_ops;
  logic [NUM_OPS-1:0]        cap_fwd_en;
  logic [NUM_OPS*DATA_W-1:0] cap_fwd_data;
  logic [NUM_OPS-1:0]        hold_fwd_en;
  logic [NUM_OPS*DATA_W-1:0] hold_fwd_data;
  logic                      out_ready;

  logic                      in_ready, in_ready_nc;
  logic                      out_valid, out_valid_nc;
  logic [DATA_W-1:0]         out_pc, out_pc_nc;
  logic [PAYLOAD_W-1:0]      out_payload, out_payload_nc;
  logic [NUM_OPS*DATA_W-1:0] out_ops, out_ops_nc;
  logic [CNT_W-1:0]          stall_cnt, stall_cnt_nc;
  logic [CNT_W-1:0]          flush_cnt, flush_cnt_nc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(
    .DATA_W(DATA_W), .NUM_OPS(NUM_OPS), .PAYLOAD_W(PAYLOAD_W),
    .CLEAR_ON_FLUSH(1'b1), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_payload(in_payload), .in_ops(in_ops),
    .cap_fwd_en(cap_fwd_en), .cap_fwd_data(cap_fwd_data),
    .hold_fwd_en(hold_fwd_en), .hold_fwd_data(hold_fwd_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_payload(out_payload), .out_ops(out_ops),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_stage_skid #(
    .DATA_W(DATA_W), .NUM_OPS(NUM_OPS), .PAYLOAD_W(PAYLOAD_W),
    .CLEAR_ON_FLUSH(1'b0), .CNT_W(CNT_W)
  ) dut_nc (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_nc),
    .in_pc(in_pc), .in_payload(in_payload), .in_ops(in_ops),
    .cap_fwd_en(cap_fwd_en), .cap_fwd_data(cap_fwd_data),
    .hold_fwd_en(hold_fwd_en), .hold_fwd_data(hold_fwd_data),
    .out_valid(out_valid_nc), .out_ready(out_ready),
    .out_pc(out_pc_nc), .out_payload(out_payload_nc), .out_ops(out_ops_nc),
    .stall_cnt(stall_cnt_nc), .flush_cnt(flush_cnt_nc)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] pc, input logic [31:0] op1, input logic [31:0] op0);
    in_valid = 1'b1;
    in_pc    = pc;
    in_ops   = {op1, op0};
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_payload = '0;
    in_ops = '0; cap_fwd_en = '0; cap_fwd_data = '0; hold_fwd_en = '0;
    hold_fwd_data = '0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;

    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_out_pc",    64'(out_pc),    64'd0);
    chk("rst_stall",     64'(stall_cnt), 64'd0);
    chk("rst_flush",     64'(flush_cnt), 64'd0);

    // 1: streaming
    out_ready = 1'b1;
    in_payload = 64'h0000_00A5_0000_0001;
    send(32'h100, 32'h22, 32'h11);
    tick();
    chk("t1_valid",   64'(out_valid), 64'd1);
    chk("t1_pc",      64'(out_pc),    64'h100);
    chk("t1_ops",     out_ops,        {32'h22, 32'h11});
    chk("t1_payload", out_payload,    64'h0000_00A5_0000_0001);
    send(32'h104, 32'h24, 32'h14);
    tick();
    chk("t1_pc2", 64'(out_pc), 64'h104);
    send(32'h108, 32'h28, 32'h18);
    tick();
    chk("t1_pc3",   64'(out_pc),    64'h108);
    chk("t1_valid3", 64'(out_valid), 64'd1);
    in_valid = 1'b0;
    tick();
    chk("t1_drain", 64'(out_valid), 64'd0);
    chk("t1_stall", 64'(stall_cnt), 64'd0);

    // 2: backpressure into skid
    out_ready = 1'b0;
    send(32'h100, 32'h2, 32'h1);
    tick();
    send(32'h104, 32'h4, 32'h3);
    tick();
    chk("t2_in_ready", 64'(in_ready), 64'd0);
    chk("t2_pc_held",  64'(out_pc),   64'h100);
    in_valid = 1'b0;
    tick();
    chk("t2_pc_held2", 64'(out_pc),    64'h100);
    chk("t2_stall2",   64'(stall_cnt), 64'd2);
    out_ready = 1'b1;
    tick();
    chk("t2_pc_skid",  64'(out_pc),    64'h104);
    chk("t2_ops_skid", out_ops,        {32'h4, 32'h3});
    chk("t2_in_ready2", 64'(in_ready), 64'd1);
    chk("t2_stall",    64'(stall_cnt), 64'd2);
    tick();
    chk("t2_empty", 64'(out_valid), 64'd0);

    // 3: forwarding at capture and on a held entry
    send(32'h200, 32'h44, 32'h33);
    cap_fwd_en = 2'b10;
    cap_fwd_data = {32'hDEAD, 32'h9999};
    tick();
    chk("t3_cap_ops", out_ops, {32'hDEAD, 32'h33});
    in_valid = 1'b0; cap_fwd_en = '0; out_ready = 1'b0;
    hold_fwd_en = 2'b01;
    hold_fwd_data = {32'h7777, 32'hBEEF};
    tick();
    chk("t3_hold_ops", out_ops,        {32'hDEAD, 32'hBEEF});
    chk("t3_stall",    64'(stall_cnt), 64'd3);
    hold_fwd_en = '0;

    // 4: flush with both entries full and an input offered
    send(32'h204, 32'h66, 32'h55);
    tick();
    chk("t4_in_ready_full", 64'(in_ready), 64'd0);
    flush = 1'b1;
    send(32'h208, 32'h88, 32'h77);
    tick();
    chk("t4_valid",     64'(out_valid),    64'd0);
    chk("t4_in_ready",  64'(in_ready),     64'd1);
    chk("t4_flush_cnt", 64'(flush_cnt),    64'd1);
    chk("t4_pc_clear",  64'(out_pc),       64'd0);
    chk("t4_ops_clear", out_ops,           64'd0);
    chk("t4_pc_keep",   64'(out_pc_nc),    64'h200);
    chk("t4_valid_nc",  64'(out_valid_nc), 64'd0);
    chk("t4_stall",     64'(stall_cnt),    64'd5);
    flush = 1'b0; in_valid = 1'b0;
    tick();
    chk("t4_dropped", 64'(out_valid), 64'd0);

    // 5: flush on an empty stage, then counter saturation
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t5_flush_empty", 64'(flush_cnt), 64'd1);
    send(32'h300, 32'h0, 32'h0);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk("t5_stall_sat", 64'(stall_cnt), 64'd15);

    // refreshed skid entry carries its value into main
    send(32'h304, 32'h2, 32'h1);
    tick();
    in_valid = 1'b0;
    hold_fwd_en = 2'b10;
    hold_fwd_data = {32'hCAFE, 32'h1234};
    tick();
    chk("t5_main_ref", out_ops, {32'hCAFE, 32'h0});
    hold_fwd_en = '0;
    out_ready = 1'b1;
    tick();
    chk("t5_skid_pc",  64'(out_pc), 64'h304);
    chk("t5_skid_ref", out_ops,     {32'hCAFE, 32'h1});

    // 6: asynchronous reset mid-stream with skid full
    out_ready = 1'b0;
    send(32'h400, 32'h0, 32'h0);
    tick();
    send(32'h404, 32'h0, 32'h0);
    tick();
    in_valid = 1'b0;
    chk("t6_skid_full", 64'(in_ready), 64'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_valid", 64'(out_valid), 64'd0);
    chk("t6_ready", 64'(in_ready),  64'd1);
    chk("t6_pc",    64'(out_pc),    64'd0);
    chk("t6_stall", 64'(stall_cnt), 64'd0);
    chk("t6_flush", 64'(flush_cnt), 64'd0);
    tick();
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Generic, parametrised ID→EX-style pipeline stage register. Successor to the fixed-width ID/EX register.
- Carries a PC, an opaque control payload and NUM_OPS operand words per instruction.
- Adds a valid/ready handshake with a 2-entry skid buffer, so backpressure does not drop instructions.
- Forwarding is applied both at capture and on held entries; flush has a selectable clear mode; saturating stall/flush counters.
- Sits between the decode and execute stages. Reusable for EX/MEM and MEM/WB.

Parameters:
- DATA_W, 32, width of the PC and of each operand word
- NUM_OPS, 2, number of operand channels
- PAYLOAD_W, 64, width of the opaque control bundle (alu_op, wd_sel, sl_type, imm, ...)
- CLEAR_ON_FLUSH, 1, 1: flush zeroes payload/pc/ops of killed entries; 0: flush clears valid only
- CNT_W, 16, width of the performance counters

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  kill all entries held in this stage
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept an entry
- in_pc  in  DATA_W  upstream PC
- in_payload  in  PAYLOAD_W  upstream control bundle
- in_ops  in  NUM_OPS*DATA_W  upstream operands; channel i = bits [i*DATA_W +: DATA_W]
- cap_fwd_en  in  NUM_OPS  per-channel select of forwarded data at capture
- cap_fwd_data  in  NUM_OPS*DATA_W  forwarded data used at capture
- hold_fwd_en  in  NUM_OPS  per-channel refresh of held entries
- hold_fwd_data  in  NUM_OPS*DATA_W  refresh data for held entries
- out_valid  out  1  main entry valid
- out_ready  in  1  downstream accepts the entry
- out_pc  out  DATA_W  main entry PC
- out_payload  out  PAYLOAD_W  main entry payload
- out_ops  out  NUM_OPS*DATA_W  main entry operands
- stall_cnt  out  CNT_W  count of cycles with out_valid && !out_ready, saturating
- flush_cnt  out  CNT_W  count of flushes that killed at least one valid entry, saturating

Behaviour:
- Reset (async, rst=1): every register is zero. out_valid=0, skid_valid=0, in_ready=1, out_pc/out_payload/out_ops=0, both counters=0.
- Storage: main entry (drives the outputs) plus one skid entry. Both entries are registered.
- in_fire = in_valid && in_ready. out_fire = out_valid && out_ready.
- in_ready = !skid_valid. It is registered-only and does not depend on flush or out_ready.
- Latency: an entry accepted at edge N appears on the outputs after edge N when the stage is empty. Throughput: 1 entry per cycle.
- Capture value: operand channel i = cap_fwd_en[i] ? cap_fwd_data[i] : in_ops[i]. PC and payload are taken unchanged.
- Update at each edge (no flush):
  - Main empty or out_fire, skid valid: main ← skid, skid becomes empty.
  - Main empty or out_fire, skid empty: main ← capture if in_fire, else main goes invalid.
  - Main valid and !out_ready: on in_fire, skid ← capture (skid is necessarily empty).
- Hold refresh: every valid entry that does not move this edge (main with !out_ready; skid not draining) takes operand channel i ← hold_fwd_data[i] when hold_fwd_en[i]=1. An entry moving skid→main carries its refreshed value.
- Flush:
  - Main and skid both become invalid at the edge.
  - Any in_fire in the same cycle is dropped; the upstream handshake still completes.
  - An out_fire in the same cycle counts as delivered.
  - CLEAR_ON_FLUSH=1: pc, payload and ops of both entries become 0. CLEAR_ON_FLUSH=0: data is retained; only valid is cleared.
  - Flush overrides hold refresh.
- Counters:
  - stall_cnt increments when out_valid && !out_ready.
  - flush_cnt increments when flush && (out_valid || skid_valid).
  - Both saturate at 2^CNT_W−1 with no wrap. Only reset clears them.
- Mid-operation reset: all state clears immediately, asynchronously. Outputs return to reset values.

Test Plan:
1. Reset, then in_valid=1 with pc=0x100 and ops={0x11,0x22}, out_ready=1 → out_valid=1 next cycle with out_pc=0x100; back-to-back entries stream with no bubbles; stall_cnt=0.
2. out_ready=0 while pc 0x100 (main) and 0x104 are sent → 0x104 goes to skid and in_ready=0. Raise out_ready → out_pc is 0x100 then 0x104, nothing lost; stall_cnt counts every held cycle.
3. cap_fwd_en=2'b10 with cap_fwd_data ch1=0xDEAD → out_ops ch1=0xDEAD, ch0=in value. Main held, hold_fwd_en=2'b01, data 0xBEEF → out_ops ch0=0xBEEF on the next cycle.
4. Main and skid valid, flush=1 with in_valid=1 → out_valid=0, in_ready=1, input dropped, flush_cnt=1. CLEAR_ON_FLUSH=1 → out_pc=0; CLEAR_ON_FLUSH=0 → out_pc unchanged.
5. flush with the stage empty → flush_cnt unchanged. Counter saturation with CNT_W=4 and 20 stall cycles → stall_cnt=15.
6. Assert rst mid-stream with skid full → out_valid=0, in_ready=1, counters=0 immediately, without waiting for a clock edge.
